// File: rtl/pipe_elastic_reg.sv
// -----------------------------------------------------------------------------
// pipe_elastic_reg
//   Elastic pipeline stage register between two valid/ready stages.
//
//   Build option: macro PIPE_SKID_EN
//     defined   -> two-entry skid buffer (EMPTY/ONE/TWO), in_ready registered,
//                  so out_ready has no combinational path to in_ready.
//     undefined -> single register (EMPTY/ONE), in_ready = !out_valid ||
//                  out_ready, gated off until the first edge after reset.
//
//   Handshake: an entry moves across a port on the rising clk edge where that
//   port's valid and ready are both high; valid never depends on ready, and
//   payload is ignored while valid is low.
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     flush         synchronous discard of held entries and same-cycle input
//     in_valid      upstream offers an entry
//     in_ready      stage accepts the entry this cycle
//     in_data       upstream payload (DATA_W bits)
//     in_instr      upstream debug instruction word
//     out_valid     stage presents its head entry
//     out_ready     downstream accepts the head entry this cycle
//     out_data      head payload, 0 when empty
//     out_instr     head debug instruction, NOP_INSTR when empty
//     occupancy     number of held entries; equals the FSM state encoding,
//                   so it doubles as the state debug view
// -----------------------------------------------------------------------------
module pipe_elastic_reg #(
   parameter int          DATA_W    = 64,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [31:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [31:0]       out_instr,
   output logic [1:0]        occupancy
);

   // Encoding chosen so the state value is the entry count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] head_data_q, head_data_d;
   logic [31:0]       head_instr_q, head_instr_d;
   logic              in_xfer;
   logic              out_xfer;

   assign out_valid = (state_q != EMPTY);
   assign out_xfer  = out_valid && out_ready;
   assign in_xfer   = in_valid && in_ready;
   assign occupancy = state_q;

   // Outputs are masked rather than relying on cleared registers, so a held
   // but discarded entry (after flush) can never leak onto out_*.
   assign out_data  = out_valid ? head_data_q  : '0;
   assign out_instr = out_valid ? head_instr_q : NOP_INSTR;

`ifdef PIPE_SKID_EN

   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [31:0]       skid_instr_q, skid_instr_d;
   logic              in_ready_q, in_ready_d;

   assign in_ready = in_ready_q;

   always_comb begin
      state_d      = state_q;
      head_data_d  = head_data_q;
      head_instr_d = head_instr_q;
      skid_data_d  = skid_data_q;
      skid_instr_d = skid_instr_q;

      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               head_data_d  = in_data;
               head_instr_d = in_instr;
               state_d      = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               // Head leaves while the new entry replaces it.
               head_data_d  = in_data;
               head_instr_d = in_instr;
            end else if (in_xfer) begin
               // Downstream stalled: park the new entry behind the head.
               skid_data_d  = in_data;
               skid_instr_d = in_instr;
               state_d      = TWO;
            end else if (out_xfer) begin
               state_d      = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only the head can move.
            if (out_xfer) begin
               head_data_d  = skid_data_q;
               head_instr_d = skid_instr_q;
               state_d      = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (flush) begin
         state_d = EMPTY;
      end

      // Registered ready: look at where the FSM is going, not at out_ready.
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         head_data_q  <= '0;
         head_instr_q <= NOP_INSTR;
         skid_data_q  <= '0;
         skid_instr_q <= NOP_INSTR;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_data_q  <= head_data_d;
         head_instr_q <= head_instr_d;
         skid_data_q  <= skid_data_d;
         skid_instr_q <= skid_instr_d;
         in_ready_q   <= in_ready_d;
      end
   end

`else

   // Holds in_ready low from reset until the first clock edge after release.
   logic ready_en_q, ready_en_d;

   assign ready_en_d = 1'b1;
   assign in_ready   = ready_en_q && (!out_valid || out_ready);

   always_comb begin
      state_d      = state_q;
      head_data_d  = head_data_q;
      head_instr_d = head_instr_q;

      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               head_data_d  = in_data;
               head_instr_d = in_instr;
               state_d      = ONE;
            end
         end
         ONE: begin
            if (in_xfer) begin
               // Accepting in ONE implies the head is leaving this cycle.
               head_data_d  = in_data;
               head_instr_d = in_instr;
            end else if (out_xfer) begin
               state_d      = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (flush) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         head_data_q  <= '0;
         head_instr_q <= NOP_INSTR;
         ready_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_data_q  <= head_data_d;
         head_instr_q <= head_instr_d;
         ready_en_q   <= ready_en_d;
      end
   end

`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_elastic_reg
//   Directed and random checks of pipe_elastic_reg against a queue model of
//   the held entries. Inputs change 1 ns after each rising edge; outputs are
//   sampled 2 ns after the edge, well away from the next one.
// -----------------------------------------------------------------------------
module tb_pipe_elastic_reg;

   localparam int          DW  = 64;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] IMK = 32'h5A5A0000;
`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [31:0]   in_instr;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [31:0]   out_instr;
   logic [1:0]    occupancy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_elastic_reg #(.DATA_W(DW), .NOP_INSTR(NOP)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_instr (out_instr),
      .occupancy (occupancy)
   );

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   logic          rdy_en_m;
   int            n_checks;
   int            n_errors;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_rdy(input logic ordy);
      if (SKID) return rdy_en_m && (exp_q.size() < 2);
      else      return rdy_en_m && ((exp_q.size() == 0) || ordy);
   endfunction

   // ---------------- driver ----------------
   // Called at posedge+1; applies inputs, checks outputs against the model,
   // then advances model and DUT across one edge and returns at posedge+1.
   task automatic drive(input logic iv, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
      logic in_x, out_x, er;
      in_valid  = iv;
      in_data   = d;
      in_instr  = d[31:0] ^ IMK;
      out_ready = ordy;
      flush     = fl;
      #1;
      er = exp_rdy(ordy);
      check("in_ready",  64'(in_ready),  64'(er));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("out_data",  out_data,  (exp_q.size() != 0) ? exp_q[0] : 64'd0);
      check("out_instr", 64'(out_instr),
            64'((exp_q.size() != 0) ? (exp_q[0][31:0] ^ IMK) : NOP));
      check("occupancy", 64'(occupancy), 64'(exp_q.size()));
      in_x  = iv && er;
      out_x = (exp_q.size() != 0) && ordy;
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
      end else begin
         if (out_x) void'(exp_q.pop_front());
         if (in_x)  exp_q.push_back(d);
      end
      rdy_en_m = 1'b1;
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rdy_en_m  = 1'b0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_instr  = '0;
      out_ready = 1'b0;

      // Reset state
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'(NOP));
      check("rst_out_data",  out_data, 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_in_ready",  64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      check("rdy_after_rst", 64'(in_ready), 64'd1);

      // Streaming 1..8, each visible one cycle after acceptance
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 64'(i), 1'b1, 1'b0);
         check("stream_data", out_data, 64'(i));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      check("stream_drained", 64'(out_valid), 64'd0);

      // Backpressure: offer 5, 6, 7 while stalled
      drive(1'b1, 64'd5, 1'b0, 1'b0);
      drive(1'b1, 64'd6, 1'b0, 1'b0);
      drive(1'b1, 64'd7, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
      check("bp_occupancy", 64'(occupancy), 64'd2);
      check("bp_in_ready",  64'(in_ready), 64'd0);
      check("bp_head",      out_data, 64'd5);
      drive(1'b1, 64'd7, 1'b1, 1'b0);
      check("bp_drain_6", out_data, 64'd6);
      drive(1'b1, 64'd7, 1'b1, 1'b0);
      check("bp_drain_7", out_data, 64'd7);
      drive(1'b0, '0, 1'b1, 1'b0);
      check("bp_empty", 64'(out_valid), 64'd0);
`else
      check("bp_occupancy", 64'(occupancy), 64'd1);
      check("bp_head",      out_data, 64'd5);
      // Same-cycle ready: stalled -> 0, released -> 1
      in_valid  = 1'b1;
      in_data   = 64'd6;
      in_instr  = 32'd6 ^ IMK;
      out_ready = 1'b0;
      #1;
      check("nsk_rdy_stall", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      #1;
      check("nsk_rdy_go", 64'(in_ready), 64'd1);
      drive(1'b1, 64'd6, 1'b1, 1'b0);
      check("nsk_xfer_6", out_data, 64'd6);
      drive(1'b1, 64'd7, 1'b1, 1'b0);
      check("nsk_xfer_7", out_data, 64'd7);
      drive(1'b0, '0, 1'b1, 1'b0);
      check("bp_empty", 64'(out_valid), 64'd0);
`endif

      // Flush while full (or one held), with an input offered the same cycle
      drive(1'b1, 64'd3, 1'b0, 1'b0);
      drive(1'b1, 64'd4, 1'b0, 1'b0);
      drive(1'b1, 64'd9, 1'b0, 1'b1);
      check("flush_occupancy", 64'(occupancy), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_out_instr", 64'(out_instr), 64'(NOP));
      drive(1'b0, '0, 1'b1, 1'b0);
      check("flush_no_9", 64'(out_valid), 64'd0);

      // Mid-cycle reset with an entry in flight
      drive(1'b1, 64'd11, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_instr", 64'(out_instr), 64'(NOP));
      check("mid_rst_occupancy", 64'(occupancy), 64'd0);
      check("mid_rst_out_data",  out_data, 64'd0);
      exp_q.delete();
      rdy_en_m = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_rdy_low", 64'(in_ready), 64'd0);
      @(posedge clk);
      rdy_en_m = 1'b1;
      #1;
      check("mid_rst_rdy_high", 64'(in_ready), 64'd1);

      // Random traffic against the model
      for (int c = 0; c < 10000; c++) begin
         drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
